// File: rtl/snn_spike_count_classifier.sv
`default_nettype none
// ============================================================================
// Module      : snn_spike_count_classifier
// Description : Output-layer readout for the SNN pipeline. Accumulates the
//               per-neuron output spikes over one frame of N_STEPS timesteps
//               into saturating counters, then scans the counters one neuron
//               per cycle and reports the argmax (ties go to the lowest index).
// Ports       : clk            - clock, all state on the rising edge
//               rst_n          - asynchronous active-low reset
//               frame_start_i  - pulse: clear counters and begin a new frame
//               step_valid_i   - pulse: spikes_bits_i holds one timestep
//               spikes_bits_i  - spike vector, bit i = neuron i
//               busy_o         - high while a frame or scan is in progress
//               class_valid_o  - one-cycle pulse, result outputs updated
//               class_id_o     - index of the winning neuron
//               class_count_o  - spike count of the winner
//               class_none_o   - every counter was zero for the frame
// Revision    : 1.0 - initial release
// ============================================================================
module snn_spike_count_classifier #(
  parameter int N_CLS   = 10,
  parameter int N_STEPS = 25,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start_i,
  input  logic                       step_valid_i,
  input  logic [N_CLS-1:0]           spikes_bits_i,
  output logic                       busy_o,
  output logic                       class_valid_o,
  output logic [$clog2(N_CLS)-1:0]   class_id_o,
  output logic [CNT_W-1:0]           class_count_o,
  output logic                       class_none_o
);

  localparam int ID_W   = $clog2(N_CLS);
  localparam int STEP_W = $clog2(N_STEPS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);
  localparam logic [ID_W-1:0]   LAST_IDX  = ID_W'(N_CLS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [N_CLS];
  logic [STEP_W-1:0] step_cnt_q;
  logic [ID_W-1:0]   idx_q;
  logic [CNT_W-1:0]  best_cnt_q;
  logic [ID_W-1:0]   best_id_q;
  logic              class_valid_q;
  logic [ID_W-1:0]   class_id_q;
  logic [CNT_W-1:0]  class_count_q;
  logic              class_none_q;

  logic              w_last_step;
  logic [CNT_W-1:0]  w_cand_cnt;
  logic [CNT_W-1:0]  w_best_cnt;
  logic [ID_W-1:0]   w_best_id;

  assign w_last_step = (step_cnt_q == LAST_STEP);

  // Running best after evaluating the current scan index. Index 0 always
  // loads; later indices replace only on a strictly greater count, which
  // keeps ties on the lowest index.
  always_comb begin
    w_cand_cnt = cnt_q[idx_q];
    w_best_cnt = best_cnt_q;
    w_best_id  = best_id_q;
    if ((idx_q == '0) || (w_cand_cnt > best_cnt_q)) begin
      w_best_cnt = w_cand_cnt;
      w_best_id  = idx_q;
    end
  end

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (frame_start_i) begin
      state_d = S_ACCUM;
    end else begin
      case (state_q)
        S_ACCUM: if (step_valid_i && w_last_step) state_d = S_SCAN;
        S_SCAN:  if (idx_q == LAST_IDX)           state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  assign class_valid_o = class_valid_q;
  assign class_id_o    = class_id_q;
  assign class_count_o = class_count_q;
  assign class_none_o  = class_none_q;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CLS; i++) cnt_q[i] <= '0;
      step_cnt_q    <= '0;
      idx_q         <= '0;
      best_cnt_q    <= '0;
      best_id_q     <= '0;
      class_valid_q <= 1'b0;
      class_id_q    <= '0;
      class_count_q <= '0;
      class_none_q  <= 1'b0;
    end else begin
      class_valid_q <= 1'b0;
      if (frame_start_i) begin
        // Abort anything in progress; a coincident step is dropped and the
        // held result outputs are left untouched.
        for (int i = 0; i < N_CLS; i++) cnt_q[i] <= '0;
        step_cnt_q <= '0;
        idx_q      <= '0;
        best_cnt_q <= '0;
        best_id_q  <= '0;
      end else begin
        case (state_q)
          S_ACCUM: begin
            if (step_valid_i) begin
              for (int i = 0; i < N_CLS; i++) begin
                if (spikes_bits_i[i] && (cnt_q[i] != CNT_MAX)) begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
                end
              end
              step_cnt_q <= step_cnt_q + 1'b1;
              if (w_last_step) idx_q <= '0;
            end
          end
          S_SCAN: begin
            best_cnt_q <= w_best_cnt;
            best_id_q  <= w_best_id;
            if (idx_q == LAST_IDX) begin
              idx_q         <= '0;
              class_valid_q <= 1'b1;
              class_count_q <= w_best_cnt;
              class_none_q  <= (w_best_cnt == '0);
              class_id_q    <= (w_best_cnt == '0) ? '0 : w_best_id;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
